// File: rtl/rv_fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the {ir,pc} entry
// carried through the output register and skid, and the canonical NOP.
package rv_fetch_unit_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_fetch_skid.sv
// One-entry {ir,pc} holding buffer behind the fetch output register.
// Flush wins over push; a push in the same cycle as a pop replaces the entry.
module rv_fetch_skid
    import rv_fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t push_data_i,
    output logic         full_o,
    output fetch_entry_t data_o
);

    logic         full_q, full_d;
    fetch_entry_t data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d = 1'b1;
            data_d = push_data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory read in flight,
// and hands {ir,pc} downstream through an output register backed by a skid entry.
module rv_fetch_unit
    import rv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic [31:0]  im_addr_o,
    output logic         im_rd_o,
    input  logic [31:0]  im_data_i,
    input  logic         im_valid_i,
    input  logic         x_bra_i,
    input  logic [31:0]  x_bra_target_i,
    input  logic         f_stall_i,
    output logic         f_valid_o,
    output logic [31:0]  f_ir_o,
    output logic [31:0]  f_pc_o,
    output fetch_state_e dbg_state_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         f_valid_q, f_valid_d;
    logic [31:0]  f_ir_q, f_ir_d;
    logic [31:0]  f_pc_q, f_pc_d;

    logic         resp;
    logic         out_free;
    logic         issue;
    logic [31:0]  issue_addr;
    logic         skid_full, skid_push, skid_pop, skid_full_next;
    fetch_entry_t skid_data;
    fetch_entry_t resp_entry;

    // A response is live only for a request that was not squashed by a redirect.
    assign resp       = (state_q == ST_BUSY) && im_valid_i && !x_bra_i;
    assign out_free   = !f_valid_q || !f_stall_i;
    assign resp_entry = '{ir: im_data_i, pc: pc_q};

    always_comb begin
        f_valid_d = f_valid_q;
        f_ir_d    = f_ir_q;
        f_pc_d    = f_pc_q;
        skid_push = 1'b0;
        skid_pop  = 1'b0;
        if (x_bra_i) begin
            f_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                f_valid_d = 1'b1;
                f_ir_d    = skid_data.ir;
                f_pc_d    = skid_data.pc;
                skid_pop  = 1'b1;
                skid_push = resp;
            end else if (resp) begin
                f_valid_d = 1'b1;
                f_ir_d    = im_data_i;
                f_pc_d    = pc_q;
            end else begin
                f_valid_d = 1'b0;
            end
        end else begin
            skid_push = resp;
        end
        skid_full_next = skid_push || (skid_full && !skid_pop);
    end

    // pc_q always holds the address of the request in flight (or the next one to issue).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue      = 1'b0;
        issue_addr = pc_q;
        case (state_q)
            ST_RESET: begin
                if (x_bra_i) begin
                    state_d = ST_IDLE;
                end else begin
                    issue   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_IDLE: begin
                if (!x_bra_i && !skid_full) begin
                    issue   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (x_bra_i) begin
                    state_d = im_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (resp) begin
                    pc_d = pc_q + 32'd4;
                    if (!skid_full_next) begin
                        issue      = 1'b1;
                        issue_addr = pc_q + 32'd4;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (im_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (x_bra_i) begin
            pc_d = word_align(x_bra_target_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RESET;
            pc_q      <= RESET_VECTOR;
            f_valid_q <= 1'b0;
            f_ir_q    <= RV_NOP;
            f_pc_q    <= RESET_VECTOR;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_valid_q <= f_valid_d;
            f_ir_q    <= f_ir_d;
            f_pc_q    <= f_pc_d;
        end
    end

    rv_fetch_skid u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (x_bra_i),
        .push_i      (skid_push),
        .pop_i       (skid_pop),
        .push_data_i (resp_entry),
        .full_o      (skid_full),
        .data_o      (skid_data)
    );

    // The request strobe is combinational so a returning word can launch the next read
    // in the same cycle; it is held low while reset is asserted.
    assign im_rd_o     = issue && !rst_i;
    assign im_addr_o   = issue_addr;
    assign f_valid_o   = f_valid_q;
    assign f_ir_o      = f_ir_q;
    assign f_pc_o      = f_pc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed and randomized bench for rv_fetch_unit against a program-order fetch model
// and a variable-latency single-port instruction memory.
module tb_rv_fetch_unit;
  import rv_fetch_unit_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic         clk;
  logic         rst_i;
  logic [31:0]  im_addr_o;
  logic         im_rd_o;
  logic [31:0]  im_data_i;
  logic         im_valid_i;
  logic         x_bra_i;
  logic [31:0]  x_bra_target_i;
  logic         f_stall_i;
  logic         f_valid_o;
  logic [31:0]  f_ir_o;
  logic [31:0]  f_pc_o;
  fetch_state_e dbg_state_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] exp_pc;
  logic        prev_flush;
  logic        mem_busy;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_addr;

  rv_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .im_addr_o      (im_addr_o),
    .im_rd_o        (im_rd_o),
    .im_data_i      (im_data_i),
    .im_valid_i     (im_valid_i),
    .x_bra_i        (x_bra_i),
    .x_bra_target_i (x_bra_target_i),
    .f_stall_i      (f_stall_i),
    .f_valid_o      (f_valid_o),
    .f_ir_o         (f_ir_o),
    .f_pc_o         (f_pc_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'h3C6E_F35F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observe one cycle at the falling edge and update the reference model.
  task automatic sample();
    @(negedge clk);
    if (prev_flush) chk("flush_clears_valid", 32'(f_valid_o), 32'd0);
    if (rst_i) begin
      chk("rst_no_rd", 32'(im_rd_o), 32'd0);
      exp_pc = RV;
    end else begin
      if (im_rd_o) begin
        chk("single_outstanding", 32'(mem_busy), 32'd0);
        chk("addr_align", 32'(im_addr_o[1:0]), 32'd0);
        mem_busy = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = im_addr_o;
      end
      if (f_valid_o) begin
        chk("out_pc", f_pc_o, exp_pc);
        chk("out_ir", f_ir_o, mem_word(exp_pc));
        if (!f_stall_i) exp_pc = exp_pc + 32'd4;
      end
      if (x_bra_i) exp_pc = {x_bra_target_i[31:2], 2'b00};
    end
    prev_flush = rst_i || x_bra_i;
  endtask

  // Step past the rising edge and let the memory model drive the next cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    im_valid_i = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        im_valid_i = 1'b1;
        im_data_i  = mem_word(mem_addr);
        mem_busy   = 1'b0;
      end
    end
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // Returns right after the sample of the cycle in which im_rd_o is seen.
  task automatic wait_rd(input int max, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      sample();
      if (im_rd_o) begin
        got = 1'b1;
        break;
      end
      advance();
    end
    if (!got) sample();
    chk(tag, 32'(got), 32'd1);
  endtask

  // Steps until the coming cycle has both a valid output and a returning word.
  task automatic wait_resp_with_out(input int max, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (im_valid_i && f_valid_o) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] first_rd;
    logic [31:0] rd_a0, rd_a1;
    int          n_rd;
    bit          seen, got;

    rst_i = 1'b1; im_data_i = '0; im_valid_i = 1'b0; x_bra_i = 1'b0;
    x_bra_target_i = '0; f_stall_i = 1'b0;
    exp_pc = RV; prev_flush = 1'b0; mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_addr = '0;

    // reset values
    advance();
    sample();
    chk("rst_im_rd", 32'(im_rd_o), 32'd0);
    chk("rst_im_addr", im_addr_o, RV);
    chk("rst_f_valid", 32'(f_valid_o), 32'd0);
    chk("rst_f_ir", f_ir_o, RV_NOP);
    chk("rst_f_pc", f_pc_o, RV);
    chk("rst_state", 32'(dbg_state_o), 32'(ST_RESET));
    advance();

    // 1: streaming with 1-cycle memory
    rst_i = 1'b0;
    sample();
    chk("t1_rd0", 32'(im_rd_o), 32'd1);
    chk("t1_addr0", im_addr_o, 32'h0);
    chk("t1_valid0", 32'(f_valid_o), 32'd0);
    advance();
    sample();
    chk("t1_rd1", 32'(im_rd_o), 32'd1);
    chk("t1_addr1", im_addr_o, 32'h4);
    chk("t1_valid1", 32'(f_valid_o), 32'd0);
    advance();
    for (int k = 2; k < 8; k++) begin
      sample();
      chk("t1_valid", 32'(f_valid_o), 32'd1);
      chk("t1_pc", f_pc_o, 32'(4 * (k - 2)));
      chk("t1_rd", 32'(im_rd_o), 32'd1);
      chk("t1_addr", im_addr_o, 32'(4 * k));
      advance();
    end

    // 2: three stalled cycles, then release
    f_stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t2_rd_stopped", 32'(im_rd_o), 32'd0);
      chk("t2_pc_frozen", f_pc_o, 32'd24);
      advance();
    end
    f_stall_i = 1'b0;
    for (int k = 0; k < 8; k++) step();

    // 3: redirect with a request in flight
    mem_lat = 3;
    wait_rd(10, "t3_rd_seen");
    advance();
    x_bra_i = 1'b1; x_bra_target_i = 32'h0000_0102;
    sample();
    chk("t3_bra_no_rd", 32'(im_rd_o), 32'd0);
    advance();
    x_bra_i = 1'b0;
    seen = 1'b0; got = 1'b0; first_rd = '0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (im_rd_o && !seen) begin
        seen = 1'b1;
        first_rd = im_addr_o;
      end
      if (f_valid_o) begin
        got = 1'b1;
        break;
      end
      advance();
    end
    chk("t3_first_addr", first_rd, 32'h0000_0100);
    chk("t3_valid_seen", 32'(got), 32'd1);
    chk("t3_target_pc", f_pc_o, 32'h0000_0100);
    advance();

    // 4a: redirect with skid full, stalled output and a spurious memory valid
    mem_lat = 1;
    wait_resp_with_out(40, "t4a_steady");
    f_stall_i = 1'b1;
    sample();
    chk("t4a_skid_fill_no_rd", 32'(im_rd_o), 32'd0);
    advance();
    x_bra_i = 1'b1; x_bra_target_i = 32'h0000_0203;
    im_valid_i = 1'b1; im_data_i = 32'hBAD0_BAD0;
    sample();
    chk("t4a_bra_no_rd", 32'(im_rd_o), 32'd0);
    advance();
    x_bra_i = 1'b0; f_stall_i = 1'b0;
    sample();
    chk("t4a_valid_cleared", 32'(f_valid_o), 32'd0);
    chk("t4a_state_idle", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("t4a_rd", 32'(im_rd_o), 32'd1);
    chk("t4a_addr", im_addr_o, 32'h0000_0200);
    advance();

    // 4b: redirect coincident with a live response while stalled
    wait_resp_with_out(40, "t4b_steady");
    f_stall_i = 1'b1; x_bra_i = 1'b1; x_bra_target_i = 32'h0000_0301;
    sample();
    chk("t4b_bra_no_rd", 32'(im_rd_o), 32'd0);
    advance();
    x_bra_i = 1'b0; f_stall_i = 1'b0;
    sample();
    chk("t4b_valid_cleared", 32'(f_valid_o), 32'd0);
    chk("t4b_state_idle", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("t4b_rd", 32'(im_rd_o), 32'd1);
    chk("t4b_addr", im_addr_o, 32'h0000_0300);
    advance();

    // 5: PC wrap at the top of the address space with 3-cycle memory
    mem_lat = 3;
    x_bra_i = 1'b1; x_bra_target_i = 32'hFFFF_FFFF;
    step();
    x_bra_i = 1'b0;
    n_rd = 0; rd_a0 = '0; rd_a1 = '0;
    for (int i = 0; i < 40 && n_rd < 2; i++) begin
      sample();
      if (im_rd_o) begin
        if (n_rd == 0) rd_a0 = im_addr_o;
        else rd_a1 = im_addr_o;
        n_rd++;
      end
      advance();
    end
    chk("t5_rd_count", 32'(n_rd), 32'd2);
    chk("t5_addr_top", rd_a0, 32'hFFFF_FFFC);
    chk("t5_addr_wrap", rd_a1, 32'h0000_0000);
    for (int k = 0; k < 8; k++) step();

    // 6: reset mid-request, stale response arrives in the first cycle after release
    wait_rd(10, "t6_rd_seen");
    advance();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    mem_busy = 1'b0;
    im_valid_i = 1'b1; im_data_i = 32'hDEAD_BEEF;
    sample();
    chk("t6_state_reset", 32'(dbg_state_o), 32'(ST_RESET));
    chk("t6_rd", 32'(im_rd_o), 32'd1);
    chk("t6_addr", im_addr_o, RV);
    advance();
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (f_valid_o) begin
        got = 1'b1;
        break;
      end
      advance();
    end
    chk("t6_valid_seen", 32'(got), 32'd1);
    chk("t6_pc", f_pc_o, RV);
    chk("t6_ir", f_ir_o, mem_word(RV));
    advance();

    // randomized stalls, latencies and redirects
    for (int i = 0; i < 1500; i++) begin
      f_stall_i = ($urandom_range(0, 3) == 0);
      mem_lat   = $urandom_range(1, 3);
      x_bra_i   = ($urandom_range(0, 19) == 0);
      x_bra_target_i = $urandom;
      step();
    end
    x_bra_i = 1'b0; f_stall_i = 1'b0;
    for (int k = 0; k < 10; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
